iterative_divider: RTL and testbench

- Sequential restoring divider: unsigned N-bit dividend / N-bit divisor, one quotient bit per clock.
- Each iteration's trial subtraction runs on an (N+1)-bit add/subtract stage, computed as A + ~B + 1, with its carry-out used as the "no-borrow" flag.
- This block is the control and datapath stage that drives that adder and consumes its Sum/Cout each cycle.
- Sits between the operand-entry logic (switches/registers) and the result display/consumer.

---
 rtl/iterative_divider_pkg.sv | 17 +
 rtl/div_addsub.sv | 18 +
 rtl/iterative_divider.sv | 115 +++++++++++
 tb/tb_iterative_divider.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/iterative_divider_pkg.sv
// Shared types and constants for the iterative divider.
// State encoding, default width and counter sizing.
package iterative_divider_pkg;

  localparam int DIV_N = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_addsub.sv
// Ripple add/subtract stage: {cout, sum} = a + b + cin.
// Subtraction is done by the caller passing ~b and cin=1.
module div_addsub #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // full-width add with carry-out as the top bit
  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  end

endmodule

// File: rtl/iterative_divider.sv
// Restoring divider: one quotient bit per clock.
// Trial subtraction through div_addsub; carry-out means no borrow.
module iterative_divider
  import iterative_divider_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  logic [N:0]    r;
  logic [N-1:0]  q;
  logic [N-1:0]  d;
  logic [CW-1:0] cnt;

  logic [N:0]    shifted;
  logic [N:0]    add_b;
  logic [N:0]    sum;
  logic          cout;
  logic [N:0]    r_nx;
  logic [N-1:0]  q_nx;

  // shift in next dividend bit and form trial subtraction operands
  always_comb begin
    shifted = (r << 1) | {{N{1'b0}}, q[N-1]};
    add_b   = ~{1'b0, d};
  end

  div_addsub #(
    .W (N + 1)
  ) u_addsub (
    .a    (shifted),
    .b    (add_b),
    .cin  (1'b1),
    .sum  (sum),
    .cout (cout)
  );

  // restore on borrow, keep difference otherwise
  always_comb begin
    r_nx = cout ? sum : shifted;
    q_nx = {q[N-2:0], cout};
  end

  // control FSM, working registers and registered results
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (start) begin
            d           <= divisor;
            q           <= dividend;
            r           <= '0;
            cnt         <= '0;
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          r   <= r_nx;
          q   <= q_nx;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_nx;
            remainder <= r_nx[N-1:0];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
// Bench for iterative_divider at N=4.
// Reference results come from plain integer / and %.
module tb_iterative_divider;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int vectors = 0;
  int miscompares = 0;

  iterative_divider #(.N(N)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic launch(input int a, input int b);
    start    = 1'b1;
    dividend = N'(a);
    divisor  = N'(b);
    tick();
    start    = 1'b0;
    dividend = N'($urandom);
    divisor  = N'($urandom);
  endtask

  task automatic await_done(input int a, input int b,
                            input int n0, input int b0);
    int n;
    int bz;
    int eq;
    int er;
    n  = n0;
    bz = b0;
    eq = (b == 0) ? (1 << N) - 1 : a / b;
    er = (b == 0) ? a : a % b;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
      bz += (busy === 1'b1) ? 1 : 0;
    end
    chk($sformatf("latency %0d/%0d", a, b), n, (b == 0) ? 1 : N + 1);
    chk($sformatf("busy_cycles %0d/%0d", a, b), bz, (b == 0) ? 0 : N);
    chk($sformatf("quotient %0d/%0d", a, b), int'(quotient), eq);
    chk($sformatf("remainder %0d/%0d", a, b), int'(remainder), er);
    chk($sformatf("dbz %0d/%0d", a, b), int'(div_by_zero), (b == 0) ? 1 : 0);
    if (b != 0) begin
      chk($sformatf("identity %0d/%0d", a, b),
          int'(quotient) * b + int'(remainder), a);
      chk($sformatf("rem_lt %0d/%0d", a, b),
          (int'(remainder) < b) ? 1 : 0, 1);
    end
  endtask

  task automatic div(input int a, input int b);
    launch(a, b);
    await_done(a, b, 1, (busy === 1'b1) ? 1 : 0);
  endtask

  initial begin
    int dn;
    int bz;
    int a;
    int b;

    tick();
    tick();
    chk("rst quotient", int'(quotient), 0);
    chk("rst remainder", int'(remainder), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst dbz", int'(div_by_zero), 0);
    reset_n = 1'b1;
    tick();

    div(13, 3);
    tick();
    chk("hold done low", int'(done), 0);
    chk("hold quotient", int'(quotient), 4);
    chk("hold remainder", int'(remainder), 1);

    div(15, 1);
    div(2, 7);
    tick();

    div(9, 0);
    tick();
    chk("dbz held", int'(div_by_zero), 1);
    chk("dbz q held", int'(quotient), 15);
    launch(6, 2);
    chk("dbz clr on accept", int'(div_by_zero), 0);
    chk("q kept on accept", int'(quotient), 15);
    await_done(6, 2, 1, (busy === 1'b1) ? 1 : 0);
    tick();

    launch(14, 4);
    bz = (busy === 1'b1) ? 1 : 0;
    start    = 1'b1;
    dividend = 4'd8;
    divisor  = 4'd2;
    tick();
    start = 1'b0;
    bz += (busy === 1'b1) ? 1 : 0;
    await_done(14, 4, 2, bz);
    tick();

    launch(12, 5);
    tick();
    reset_n = 1'b0;
    #1;
    chk("async rst quotient", int'(quotient), 0);
    chk("async rst remainder", int'(remainder), 0);
    chk("async rst busy", int'(busy), 0);
    tick();
    reset_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      dn += (done === 1'b1) ? 1 : 0;
    end
    chk("no done after abort", dn, 0);
    div(12, 5);
    tick();

    for (int i = 0; i < 20; i++) begin
      a = int'($urandom_range(15, 0));
      b = int'($urandom_range(15, 0));
      div(a, b);
      if ($urandom_range(1, 0) == 1) tick();
    end

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        div(x, y);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
